// File: rtl/pcs_pkg.sv
// Shared definitions for the 1000BASE-X code-group synchroniser: comma encodings,
// synchronisation state type and the comma-match helper.
package pcs_pkg;

    localparam logic [9:0] K28_1_RDN = 10'b0011111001;
    localparam logic [9:0] K28_1_RDP = 10'b1100000110;
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;
    localparam logic [9:0] K28_7_RDN = 10'b0011111000;
    localparam logic [9:0] K28_7_RDP = 10'b1100000111;

    typedef enum logic [1:0] {
        LOSS_OF_SYNC  = 2'd0,
        COMMA_DETECT  = 2'd1,
        ACQUIRE_SYNC  = 2'd2,
        SYNC_ACQUIRED = 2'd3
    } sync_state_e;

    // True when the raw code-group carries a comma in either running disparity.
    function automatic logic is_comma(input logic [9:0] cg);
        logic match;
        case (cg)
            K28_1_RDN, K28_1_RDP,
            K28_5_RDN, K28_5_RDP,
            K28_7_RDN, K28_7_RDP: match = 1'b1;
            default:              match = 1'b0;
        endcase
        return match;
    endfunction

endpackage

// File: rtl/pcs_sync_lane.sv
// One lane of code-group synchronisation with graded error tolerance.
// The saturating loss-of-sync counter exists only when PCS_SYNC_LOSS_CNT_EN is defined.
module pcs_sync_lane
    import pcs_pkg::*;
#(
    parameter int ACQ_COMMAS   = 3,
    parameter int GOOD_CGS_MAX = 3,
    parameter int BAD_LEVELS   = 3,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_signal_detect,
    input  logic [9:0]       i_pudi,
    input  logic             i_cg_invalid,
    input  logic             i_cg_control,
    input  logic             i_loss_cnt_clr,
    output logic             o_code_sync_status,
    output logic             o_rx_even,
    output logic [CNT_W-1:0] o_loss_cnt
);

    localparam int CC_W = $clog2(ACQ_COMMAS + 1);
    localparam int GC_W = $clog2(GOOD_CGS_MAX + 1);
    localparam int LV_W = $clog2(BAD_LEVELS + 1);
    localparam logic [CC_W-1:0] ACQ_C  = CC_W'(ACQ_COMMAS);
    localparam logic [GC_W-1:0] GOOD_C = GC_W'(GOOD_CGS_MAX);
    localparam logic [LV_W-1:0] BAD_L  = LV_W'(BAD_LEVELS);

    sync_state_e     r_state, w_state_nxt;
    logic [CC_W-1:0] r_comma_cnt, w_comma_nxt;
    logic [GC_W-1:0] r_good_cnt, w_good_nxt, w_good_inc;
    logic [LV_W-1:0] r_level, w_level_nxt;
    logic            r_sync, w_sync_nxt;
    logic            r_even, w_even_nxt;
    logic            w_comma, w_data, w_cgbad, w_enter_cd, w_loss_evt;

    // A comma arriving while rx_even is set sits in an odd position and counts as bad.
    assign w_comma    = is_comma(i_pudi) & ~i_cg_invalid;
    assign w_data     = ~i_cg_control & ~i_cg_invalid;
    assign w_cgbad    = i_cg_invalid | (w_comma & r_even);
    assign w_good_inc = r_good_cnt + GC_W'(1);

    // Next-state and counter updates; loss of signal_detect overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_comma_nxt = r_comma_cnt;
        w_level_nxt = r_level;
        w_good_nxt  = r_good_cnt;
        w_enter_cd  = 1'b0;
        if (!i_signal_detect) begin
            w_state_nxt = LOSS_OF_SYNC;
        end else begin
            case (r_state)
                LOSS_OF_SYNC: begin
                    if (w_comma) begin
                        w_state_nxt = COMMA_DETECT;
                        w_comma_nxt = CC_W'(1);
                        w_enter_cd  = 1'b1;
                    end else begin
                        w_state_nxt = LOSS_OF_SYNC;
                    end
                end
                COMMA_DETECT: begin
                    if (!w_data) begin
                        w_state_nxt = LOSS_OF_SYNC;
                    end else if (r_comma_cnt == ACQ_C) begin
                        w_state_nxt = SYNC_ACQUIRED;
                        w_level_nxt = '0;
                        w_good_nxt  = '0;
                    end else begin
                        w_state_nxt = ACQUIRE_SYNC;
                    end
                end
                ACQUIRE_SYNC: begin
                    if (w_cgbad) begin
                        w_state_nxt = LOSS_OF_SYNC;
                    end else if (w_comma) begin
                        w_state_nxt = COMMA_DETECT;
                        w_enter_cd  = 1'b1;
                        w_comma_nxt = (r_comma_cnt == ACQ_C) ? r_comma_cnt : r_comma_cnt + CC_W'(1);
                    end else begin
                        w_state_nxt = ACQUIRE_SYNC;
                    end
                end
                SYNC_ACQUIRED: begin
                    if (w_cgbad) begin
                        if (r_level == BAD_L) begin
                            w_state_nxt = LOSS_OF_SYNC;
                        end else begin
                            w_level_nxt = r_level + LV_W'(1);
                            w_good_nxt  = '0;
                        end
                    end else if (r_level != LV_W'(0)) begin
                        if (w_good_inc == GOOD_C) begin
                            w_level_nxt = r_level - LV_W'(1);
                            w_good_nxt  = '0;
                        end else begin
                            w_good_nxt  = w_good_inc;
                        end
                    end else begin
                        w_good_nxt = r_good_cnt;
                    end
                end
                default: w_state_nxt = LOSS_OF_SYNC;
            endcase
        end

        if (w_state_nxt == LOSS_OF_SYNC) begin
            w_sync_nxt = 1'b0;
        end else if ((r_state == COMMA_DETECT) && (w_state_nxt == SYNC_ACQUIRED)) begin
            w_sync_nxt = 1'b1;
        end else begin
            w_sync_nxt = r_sync;
        end
        w_even_nxt = w_enter_cd ? 1'b1 : ~r_even;
    end

    assign w_loss_evt = (r_state == SYNC_ACQUIRED) && (w_state_nxt == LOSS_OF_SYNC);

    // Lane state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= LOSS_OF_SYNC;
            r_comma_cnt <= '0;
            r_good_cnt  <= '0;
            r_level     <= '0;
            r_sync      <= 1'b0;
            r_even      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_comma_cnt <= w_comma_nxt;
            r_good_cnt  <= w_good_nxt;
            r_level     <= w_level_nxt;
            r_sync      <= w_sync_nxt;
            r_even      <= w_even_nxt;
        end
    end

    assign o_code_sync_status = r_sync;
    assign o_rx_even          = r_even;

`ifdef PCS_SYNC_LOSS_CNT_EN
    logic [CNT_W-1:0] r_loss_cnt;

    // Saturating loss counter; a clear coinciding with a loss leaves a count of one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_loss_cnt <= '0;
        end else if (i_loss_cnt_clr) begin
            r_loss_cnt <= w_loss_evt ? CNT_W'(1) : '0;
        end else if (w_loss_evt && (r_loss_cnt != {CNT_W{1'b1}})) begin
            r_loss_cnt <= r_loss_cnt + CNT_W'(1);
        end else begin
            r_loss_cnt <= r_loss_cnt;
        end
    end

    assign o_loss_cnt = r_loss_cnt;
`else
    logic w_unused_loss;
    assign w_unused_loss = i_loss_cnt_clr ^ w_loss_evt;
    assign o_loss_cnt    = '0;
`endif

endmodule

// File: rtl/pcs_sync_multi.sv
// Multi-lane code-group synchroniser: independent lanes plus a registered all-synced flag.
// Loss-of-sync counters are built when PCS_SYNC_LOSS_CNT_EN is defined.
module pcs_sync_multi #(
    parameter int LANES        = 1,
    parameter int ACQ_COMMAS   = 3,
    parameter int GOOD_CGS_MAX = 3,
    parameter int BAD_LEVELS   = 3,
    parameter int CNT_W        = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [LANES-1:0]       i_signal_detect,
    input  logic [10*LANES-1:0]    i_pudi,
    input  logic [LANES-1:0]       i_cg_invalid,
    input  logic [LANES-1:0]       i_cg_control,
    input  logic                   i_loss_cnt_clr,
    output logic [LANES-1:0]       o_code_sync_status,
    output logic [LANES-1:0]       o_rx_even,
    output logic                   o_sync_all,
    output logic [CNT_W*LANES-1:0] o_loss_cnt
);

    logic [LANES-1:0] w_css;
    logic             r_sync_all;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pcs_sync_lane #(
            .ACQ_COMMAS  (ACQ_COMMAS),
            .GOOD_CGS_MAX(GOOD_CGS_MAX),
            .BAD_LEVELS  (BAD_LEVELS),
            .CNT_W       (CNT_W)
        ) u_lane (
            .i_clk             (i_clk),
            .i_rst_n           (i_rst_n),
            .i_signal_detect   (i_signal_detect[g]),
            .i_pudi            (i_pudi[10*g +: 10]),
            .i_cg_invalid      (i_cg_invalid[g]),
            .i_cg_control      (i_cg_control[g]),
            .i_loss_cnt_clr    (i_loss_cnt_clr),
            .o_code_sync_status(w_css[g]),
            .o_rx_even         (o_rx_even[g]),
            .o_loss_cnt        (o_loss_cnt[CNT_W*g +: CNT_W])
        );
    end

    // All-lanes flag, one cycle behind the per-lane status.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_all <= 1'b0;
        end else begin
            r_sync_all <= &w_css;
        end
    end

    assign o_code_sync_status = w_css;
    assign o_sync_all         = r_sync_all;

endmodule

// File: tb/tb_pcs_sync_multi.sv
// Bench for pcs_sync_multi: a 2-lane default instance and a 1-lane small-threshold instance,
// directed scenarios followed by random traffic, checked against a behavioural model.
module tb_pcs_sync_multi;

`ifdef PCS_SYNC_LOSS_CNT_EN
    localparam bit LC_EN = 1'b1;
`else
    localparam bit LC_EN = 1'b0;
`endif
    localparam logic [9:0] K285 = 10'b0011111010;
    localparam logic [9:0] D162 = 10'b0110110101;
    localparam logic [9:0] D215 = 10'b1010101010;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  a_sd, a_inv, a_ctl, a_css, a_even;
    logic [19:0] a_pu;
    logic        a_clr, a_all;
    logic [31:0] a_lc;
    logic        b_sd, b_inv, b_ctl, b_css, b_even, b_clr, b_all;
    logic [9:0]  b_pu;
    logic [1:0]  b_lc;

    bit         in_sd[3];
    logic [9:0] in_pu[3];
    bit         in_inv[3];
    bit         in_ctl[3];
    bit         in_clr_a, in_clr_b;

    assign a_sd  = {in_sd[1], in_sd[0]};
    assign a_pu  = {in_pu[1], in_pu[0]};
    assign a_inv = {in_inv[1], in_inv[0]};
    assign a_ctl = {in_ctl[1], in_ctl[0]};
    assign a_clr = in_clr_a;
    assign b_sd  = in_sd[2];
    assign b_pu  = in_pu[2];
    assign b_inv = in_inv[2];
    assign b_ctl = in_ctl[2];
    assign b_clr = in_clr_b;

    pcs_sync_multi #(.LANES(2)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_signal_detect(a_sd), .i_pudi(a_pu),
        .i_cg_invalid(a_inv), .i_cg_control(a_ctl), .i_loss_cnt_clr(a_clr),
        .o_code_sync_status(a_css), .o_rx_even(a_even), .o_sync_all(a_all), .o_loss_cnt(a_lc)
    );

    pcs_sync_multi #(.LANES(1), .ACQ_COMMAS(1), .GOOD_CGS_MAX(2), .BAD_LEVELS(1), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_signal_detect(b_sd), .i_pudi(b_pu),
        .i_cg_invalid(b_inv), .i_cg_control(b_ctl), .i_loss_cnt_clr(b_clr),
        .o_code_sync_status(b_css), .o_rx_even(b_even), .o_sync_all(b_all), .o_loss_cnt(b_lc)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: ph 0=hunting, 1=just saw comma, 2=between commas, 3=locked.
    typedef struct {
        int ph; int commas; int lvl; int goods; bit even; bit sync; int lc;
    } mdl_t;
    mdl_t m[3];
    bit   m_all_a, m_all_b;
    int   p_acq[3]  = '{3, 3, 1};
    int   p_good[3] = '{3, 3, 2};
    int   p_bad[3]  = '{3, 3, 1};
    int   p_max[3]  = '{65535, 65535, 3};
    logic [9:0] commas[6] = '{10'b0011111001, 10'b1100000110, 10'b0011111010,
                              10'b1100000101, 10'b0011111000, 10'b1100000111};

    function automatic bit is_cm(logic [9:0] p);
        for (int i = 0; i < 6; i++) if (p == commas[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic reset_model();
        for (int l = 0; l < 3; l++) m[l] = '{0, 0, 0, 0, 1'b0, 1'b0, 0};
        m_all_a = 1'b0;
        m_all_b = 1'b0;
    endtask

    task automatic step_model();
        bit na, nb, cm, dt, bd, into_cd, evt, clr;
        int nph;
        na = m[0].sync & m[1].sync;
        nb = m[2].sync;
        for (int l = 0; l < 3; l++) begin
            cm = !in_inv[l] && is_cm(in_pu[l]);
            dt = !in_ctl[l] && !in_inv[l];
            bd = in_inv[l] || (cm && m[l].even);
            nph = m[l].ph;
            into_cd = 1'b0;
            if (!in_sd[l]) nph = 0;
            else if (m[l].ph == 0) begin
                if (cm) begin nph = 1; m[l].commas = 1; into_cd = 1'b1; end
            end else if (m[l].ph == 1) begin
                if (!dt) nph = 0;
                else if (m[l].commas == p_acq[l]) begin nph = 3; m[l].lvl = 0; m[l].goods = 0; end
                else nph = 2;
            end else if (m[l].ph == 2) begin
                if (bd) nph = 0;
                else if (cm) begin nph = 1; m[l].commas++; into_cd = 1'b1; end
            end else begin
                if (bd) begin
                    if (m[l].lvl == p_bad[l]) nph = 0;
                    else begin m[l].lvl++; m[l].goods = 0; end
                end else if (m[l].lvl > 0) begin
                    m[l].goods++;
                    if (m[l].goods == p_good[l]) begin m[l].lvl--; m[l].goods = 0; end
                end
            end
            evt = (m[l].ph == 3) && (nph == 0);
            m[l].even = into_cd ? 1'b1 : !m[l].even;
            m[l].ph = nph;
            m[l].sync = (nph == 3);
            clr = (l < 2) ? in_clr_a : in_clr_b;
            if (LC_EN) begin
                if (clr) m[l].lc = evt ? 1 : 0;
                else if (evt && m[l].lc < p_max[l]) m[l].lc++;
            end
        end
        m_all_a = na;
        m_all_b = nb;
    endtask

    function automatic logic [63:0] get_css(int l);
        return (l < 2) ? 64'(a_css[l]) : 64'(b_css);
    endfunction
    function automatic logic [63:0] get_even(int l);
        return (l < 2) ? 64'(a_even[l]) : 64'(b_even);
    endfunction
    function automatic logic [63:0] get_lc(int l);
        return (l < 2) ? 64'(a_lc[16*l +: 16]) : 64'(b_lc);
    endfunction

    // Every cycle, on the falling edge, compare all DUT outputs with the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int l = 0; l < 3; l++) begin
                chk($sformatf("css%0d", l), get_css(l), 64'(m[l].sync));
                chk($sformatf("even%0d", l), get_even(l), 64'(m[l].even));
                chk($sformatf("lc%0d", l), get_lc(l), 64'(m[l].lc));
            end
            chk("all_a", 64'(a_all), 64'(m_all_a));
            chk("all_b", 64'(b_all), 64'(m_all_b));
        end
    end

    task automatic tick();
        bit er;
        @(posedge clk);
        er = rst_n;
        #1;
        if (er) step_model();
    endtask

    task automatic put(int l, bit sd, bit k, bit inv, logic [9:0] d);
        in_sd[l]  = sd;
        in_pu[l]  = k ? K285 : d;
        in_ctl[l] = k;
        in_inv[l] = inv;
    endtask

    bit gp[3];

    initial begin
        reset_model();
        for (int l = 0; l < 3; l++) put(l, 1'b0, 1'b0, 1'b0, D162);
        in_clr_a = 1'b0;
        in_clr_b = 1'b0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        tick();
        tick();
        chk("rst_css", 64'(a_css), 64'd0);
        chk("rst_even", 64'(a_even), 64'd0);
        chk("rst_lc", 64'(a_lc), 64'd0);
        chk("rst_all", 64'(a_all), 64'd0);
        rst_n = 1'b1;

        // Lane 0: K28.5/D16.2 from reset; lane 1 sees only data.
        put(1, 1'b1, 1'b0, 1'b0, D162);
        for (int i = 0; i < 6; i++) begin
            put(0, 1'b1, (i % 2) == 0, 1'b0, D162);
            tick();
            if (i == 4) chk("pre_acq", 64'(a_css[0]), 64'd0);
        end
        chk("acq6", 64'(a_css[0]), 64'd1);
        chk("mdl_acq6", 64'(m[0].sync), 64'd1);
        chk("lane1_idle", 64'(a_css[1]), 64'd0);
        chk("even6", 64'(a_even[0]), 64'd0);

        // One invalid, three good, then three invalid: tolerated.
        for (int j = 0; j < 7; j++) begin
            put(0, 1'b1, ((6 + j) % 2) == 0, (j == 0) || (j >= 4), D162);
            tick();
        end
        chk("tol3", 64'(a_css[0]), 64'd1);
        put(0, 1'b1, 1'b0, 1'b1, D162);
        tick();
        chk("loss4", 64'(a_css[0]), 64'd0);
        chk("lc1", 64'(a_lc[15:0]), LC_EN ? 64'd1 : 64'd0);

        // Comma in an odd position while acquiring.
        put(0, 1'b1, 1'b1, 1'b0, D162); tick();
        put(0, 1'b1, 1'b0, 1'b0, D162); tick();
        put(0, 1'b1, 1'b0, 1'b0, D162); tick();
        put(0, 1'b1, 1'b1, 1'b0, D162); tick();
        chk("odd_css", 64'(a_css[0]), 64'd0);
        chk("odd_even", 64'(a_even[0]), 64'd0);
        chk("mdl_odd", 64'(m[0].ph), 64'd0);

        // Both lanes acquire together; sync_all follows one cycle later.
        for (int i = 0; i < 6; i++) begin
            put(0, 1'b1, (i % 2) == 0, 1'b0, D162);
            put(1, 1'b1, (i % 2) == 0, 1'b0, D162);
            tick();
        end
        chk("resync0", 64'(a_css[0]), 64'd1);
        chk("resync1", 64'(a_css[1]), 64'd1);
        chk("all_lag", 64'(a_all), 64'd0);
        put(0, 1'b1, 1'b1, 1'b0, D162);
        put(1, 1'b1, 1'b1, 1'b0, D162);
        tick();
        chk("all_set", 64'(a_all), 64'd1);

        // Signal detect drop on lane 0 only.
        put(0, 1'b0, 1'b0, 1'b0, D162);
        put(1, 1'b1, 1'b0, 1'b0, D162);
        tick();
        chk("sd_drop", 64'(a_css[0]), 64'd0);
        chk("indep", 64'(a_css[1]), 64'd1);
        chk("all_lag2", 64'(a_all), 64'd1);
        chk("lc2", 64'(a_lc[15:0]), LC_EN ? 64'd2 : 64'd0);
        for (int i = 0; i < 6; i++) begin
            put(0, 1'b1, (i % 2) == 0, 1'b0, D162);
            put(1, 1'b1, (i % 2) == 0, 1'b0, D162);
            tick();
            if (i == 4) chk("reacq_pre", 64'(a_css[0]), 64'd0);
        end
        chk("reacq", 64'(a_css[0]), 64'd1);

        // Small-threshold instance: fast acquisition, loss after two bad, counter saturation.
        put(0, 1'b0, 1'b0, 1'b0, D162);
        put(1, 1'b0, 1'b0, 1'b0, D162);
        put(2, 1'b1, 1'b1, 1'b0, D215); tick();
        chk("b_pre", 64'(b_css), 64'd0);
        put(2, 1'b1, 1'b0, 1'b0, D215); tick();
        chk("b_acq2", 64'(b_css), 64'd1);
        put(2, 1'b1, 1'b0, 1'b1, D215); tick();
        chk("b_tol1", 64'(b_css), 64'd1);
        put(2, 1'b1, 1'b0, 1'b1, D215); tick();
        chk("b_loss2", 64'(b_css), 64'd0);
        for (int k = 0; k < 4; k++) begin
            put(2, 1'b1, 1'b1, 1'b0, D215); tick();
            put(2, 1'b1, 1'b0, 1'b0, D215); tick();
            put(2, 1'b1, 1'b0, 1'b1, D215); tick();
            put(2, 1'b1, 1'b0, 1'b1, D215); tick();
        end
        chk("b_sat", 64'(b_lc), LC_EN ? 64'd3 : 64'd0);
        put(2, 1'b1, 1'b1, 1'b0, D215); tick();
        put(2, 1'b1, 1'b0, 1'b0, D215); tick();
        put(2, 1'b1, 1'b0, 1'b1, D215); tick();
        put(2, 1'b1, 1'b0, 1'b1, D215);
        in_clr_b = 1'b1;
        tick();
        in_clr_b = 1'b0;
        chk("b_clr", 64'(b_lc), LC_EN ? 64'd1 : 64'd0);

        // Random traffic on all lanes with a mid-run asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < 3; l++) begin
                in_sd[l] = ($urandom_range(99) >= 2);
                if (gp[l]) begin
                    in_pu[l]  = ($urandom_range(19) == 0) ? commas[$urandom_range(5)] : 10'($urandom);
                    in_ctl[l] = ($urandom_range(19) == 0);
                end else begin
                    in_pu[l]  = commas[$urandom_range(5)];
                    in_ctl[l] = 1'b1;
                end
                in_inv[l] = ($urandom_range(99) < 3);
                if ($urandom_range(99) >= 2) gp[l] = !gp[l];
            end
            in_clr_a = ($urandom_range(99) < 2);
            in_clr_b = ($urandom_range(99) < 2);
            tick();
            if (c == 1500) begin
                #2;
                rst_n = 1'b0;
                reset_model();
                tick();
                tick();
                rst_n = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
